cache_tag_ctrl: RTL and testbench

//  Parametrised tag/state/replacement store for one private MOESI L1 cache.
//  - Core port: registered tag lookup returning hit, way and state, plus a victim choice.
//  - Snoop port: independent registered lookup for the coherence bus; no replacement side effects.
//  - Tree-PLRU: replacement state is maintained internally.
//  - Init sweep: after reset, a sequential sweep invalidates the arrays; reset does not clear them in parallel.

---
 rtl/moesi_pkg.sv | 30 +++
 rtl/plru_tree.sv | 39 +++
 rtl/cache_tag_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moesi_pkg.sv
// Shared types and helpers for the MOESI L1 tag controller.
//   moesi_state_t : 3-bit coherence state encoding
//   ctrl_fsm_t    : tag controller sequencing states
//   LINE_OFF_BITS : default line-offset width (64-byte lines)
//   is_valid()    : 1 for M/O/E/S; I and unused codes count as invalid
package moesi_pkg;

  typedef enum logic [2:0] {
    ST_I = 3'b000,
    ST_M = 3'b001,
    ST_O = 3'b010,
    ST_E = 3'b100,
    ST_S = 3'b101
  } moesi_state_t;

  typedef enum logic {
    FSM_INIT = 1'b0,
    FSM_RUN  = 1'b1
  } ctrl_fsm_t;

  localparam int LINE_OFF_BITS = 6;

  function automatic logic is_valid(input logic [2:0] st);
    case (st)
      ST_M, ST_O, ST_E, ST_S: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU helper.
//   bits_i      : WAYS-1 node bits, heap order (node n has children 2n+1, 2n+2)
//   touch_way_i : way to make most-recently-used
//   next_bits_o : bits_i with the path to touch_way_i pointed away from it
//   victim_o    : way reached by following the node bits from the root
// A node bit of 0 points at the lower half, 1 at the upper half.
module plru_tree
  import moesi_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int WB   = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits_i,
  input  logic [WB-1:0]   touch_way_i,
  output logic [WAYS-2:0] next_bits_o,
  output logic [WB-1:0]   victim_o
);

  always_comb begin
    int node;
    next_bits_o = bits_i;
    node        = 0;
    for (int l = 0; l < WB; l++) begin
      next_bits_o[node] = ~touch_way_i[WB-1-l];
      node = 2*node + 1 + int'(touch_way_i[WB-1-l]);
    end
  end

  always_comb begin
    int vnode;
    victim_o = '0;
    vnode    = 0;
    for (int l = 0; l < WB; l++) begin
      victim_o[WB-1-l] = bits_i[vnode];
      vnode = 2*vnode + 1 + int'(bits_i[vnode]);
    end
  end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag / MOESI state / tree-PLRU store for one private L1 cache.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   init_busy_o           : high while the post-reset invalidation sweep runs
//   req_*  / rsp_*        : core lookup, result one cycle later, plus victim
//   snp_*  / snp_rsp_*    : snoop lookup, result one cycle later, no PLRU effect
//   upd_*                 : write one way's tag/state, optionally touch PLRU
//   par_err_o             : parity error pulse (TAG_PARITY_EN), else tied 0
// Build option: define TAG_PARITY_EN to store an even-parity bit per way over
// {tag,state}; a way failing the check is treated as a miss.
//
// state    | meaning
// FSM_INIT | sweeping set cnt_q to tag 0 / I / PLRU 0, inputs ignored
// FSM_RUN  | lookups, updates and PLRU maintenance active
module cache_tag_ctrl
  import moesi_pkg::*;
#(
  parameter  int SETS       = 128,
  parameter  int WAYS       = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int LINE_BYTES = 1 << LINE_OFF_BITS,
  localparam int SET_BITS   = $clog2(SETS),
  localparam int WAY_BITS   = $clog2(WAYS),
  localparam int OFF_BITS   = $clog2(LINE_BYTES),
  localparam int TAG_WIDTH  = ADDR_WIDTH - SET_BITS - OFF_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_busy_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_hit_o,
  output logic [WAY_BITS-1:0]   rsp_way_o,
  output logic [2:0]            rsp_state_o,
  output logic [WAY_BITS-1:0]   rsp_vict_way_o,
  output logic [TAG_WIDTH-1:0]  rsp_vict_tag_o,
  output logic [2:0]            rsp_vict_state_o,
  input  logic                  snp_valid_i,
  input  logic [ADDR_WIDTH-1:0] snp_addr_i,
  output logic                  snp_rsp_valid_o,
  output logic                  snp_hit_o,
  output logic [WAY_BITS-1:0]   snp_way_o,
  output logic [2:0]            snp_state_o,
  input  logic                  upd_en_i,
  input  logic [SET_BITS-1:0]   upd_set_i,
  input  logic [WAY_BITS-1:0]   upd_way_i,
  input  logic [TAG_WIDTH-1:0]  upd_tag_i,
  input  logic [2:0]            upd_state_i,
  input  logic                  upd_touch_i,
  output logic                  par_err_o
);

  ctrl_fsm_t              fsm_q;
  logic [SET_BITS-1:0]    cnt_q;
  logic [SET_BITS-1:0]    hit_set_q;
  logic [TAG_WIDTH-1:0]   tag_q  [SETS][WAYS];
  logic [2:0]             st_q   [SETS][WAYS];
  logic [WAYS-2:0]        plru_q [SETS];
`ifdef TAG_PARITY_EN
  logic                   par_q  [SETS][WAYS];
`endif

  logic [SET_BITS-1:0]    req_set, snp_set;
  logic [TAG_WIDTH-1:0]   req_tag, snp_tag;
  logic [OFF_BITS-1:0]    req_off_unused, snp_off_unused;
  logic [WAYS-1:0]        req_match, snp_match, req_perr, snp_perr, req_inv;
  logic                   req_hit, snp_hit;
  logic [WAY_BITS-1:0]    req_hway, snp_hway, inv_way, plru_vict, vict_way;
  logic [WAYS-2:0]        hit_plru_nxt, upd_plru_nxt, vict_nxt_unused;
  logic [WAY_BITS-1:0]    hit_vict_unused, upd_vict_unused;

  assign req_ready_o    = ~init_busy_o;
  assign req_set        = req_addr_i[OFF_BITS +: SET_BITS];
  assign req_tag        = req_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_off_unused = req_addr_i[OFF_BITS-1:0];
  assign snp_set        = snp_addr_i[OFF_BITS +: SET_BITS];
  assign snp_tag        = snp_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign snp_off_unused = snp_addr_i[OFF_BITS-1:0];

  always_comb begin
    req_match = '0;
    snp_match = '0;
    req_perr  = '0;
    snp_perr  = '0;
    req_inv   = '0;
    for (int w = 0; w < WAYS; w++) begin
`ifdef TAG_PARITY_EN
      req_perr[w] = par_q[req_set][w] != ^{tag_q[req_set][w], st_q[req_set][w]};
      snp_perr[w] = par_q[snp_set][w] != ^{tag_q[snp_set][w], st_q[snp_set][w]};
`endif
      req_match[w] = is_valid(st_q[req_set][w]) && (tag_q[req_set][w] == req_tag) && !req_perr[w];
      snp_match[w] = is_valid(st_q[snp_set][w]) && (tag_q[snp_set][w] == snp_tag) && !snp_perr[w];
      req_inv[w]   = !is_valid(st_q[req_set][w]);
    end
  end

  always_comb begin
    req_hit  = |req_match;
    snp_hit  = |snp_match;
    req_hway = '0;
    snp_hway = '0;
    inv_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (req_match[w]) req_hway = WAY_BITS'(w);
      if (snp_match[w]) snp_hway = WAY_BITS'(w);
    end
    // descending scan so the lowest-index invalid way wins
    for (int w = WAYS-1; w >= 0; w--) begin
      if (req_inv[w]) inv_way = WAY_BITS'(w);
    end
    vict_way = (|req_inv) ? inv_way : plru_vict;
  end

  plru_tree #(.WAYS(WAYS)) u_vict (
    .bits_i      (plru_q[req_set]),
    .touch_way_i (req_hway),
    .next_bits_o (vict_nxt_unused),
    .victim_o    (plru_vict)
  );

  // PLRU update for last cycle's core hit (result cycle)
  plru_tree #(.WAYS(WAYS)) u_hit (
    .bits_i      (plru_q[hit_set_q]),
    .touch_way_i (rsp_way_o),
    .next_bits_o (hit_plru_nxt),
    .victim_o    (hit_vict_unused)
  );

  // separate instance so a touch and a hit on different sets both land
  plru_tree #(.WAYS(WAYS)) u_upd (
    .bits_i      (plru_q[upd_set_i]),
    .touch_way_i (upd_way_i),
    .next_bits_o (upd_plru_nxt),
    .victim_o    (upd_vict_unused)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q            <= FSM_INIT;
      cnt_q            <= '0;
      init_busy_o      <= 1'b1;
      hit_set_q        <= '0;
      rsp_valid_o      <= 1'b0;
      rsp_hit_o        <= 1'b0;
      rsp_way_o        <= '0;
      rsp_state_o      <= '0;
      rsp_vict_way_o   <= '0;
      rsp_vict_tag_o   <= '0;
      rsp_vict_state_o <= '0;
      snp_rsp_valid_o  <= 1'b0;
      snp_hit_o        <= 1'b0;
      snp_way_o        <= '0;
      snp_state_o      <= '0;
`ifdef TAG_PARITY_EN
      par_err_o        <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        FSM_INIT: begin
          for (int w = 0; w < WAYS; w++) begin
            tag_q[cnt_q][w] <= '0;
            st_q[cnt_q][w]  <= ST_I;
`ifdef TAG_PARITY_EN
            par_q[cnt_q][w] <= 1'b0;
`endif
          end
          plru_q[cnt_q]   <= '0;
          rsp_valid_o     <= 1'b0;
          snp_rsp_valid_o <= 1'b0;
          cnt_q           <= cnt_q + SET_BITS'(1);
          if (cnt_q == SET_BITS'(SETS-1)) begin
            fsm_q       <= FSM_RUN;
            init_busy_o <= 1'b0;
          end
        end
        FSM_RUN: begin
          rsp_valid_o     <= req_valid_i;
          snp_rsp_valid_o <= snp_valid_i;
          hit_set_q       <= req_set;
          if (req_valid_i) begin
            rsp_hit_o        <= req_hit;
            rsp_way_o        <= req_hway;
            rsp_state_o      <= req_hit ? st_q[req_set][req_hway] : ST_I;
            rsp_vict_way_o   <= vict_way;
            rsp_vict_tag_o   <= tag_q[req_set][vict_way];
            rsp_vict_state_o <= st_q[req_set][vict_way];
          end else begin
            rsp_hit_o <= 1'b0;
          end
          if (snp_valid_i) begin
            snp_hit_o   <= snp_hit;
            snp_way_o   <= snp_hway;
            snp_state_o <= snp_hit ? st_q[snp_set][snp_hway] : ST_I;
          end
`ifdef TAG_PARITY_EN
          par_err_o <= (req_valid_i && |req_perr) || (snp_valid_i && |snp_perr);
`endif
          if (rsp_valid_o && rsp_hit_o) plru_q[hit_set_q] <= hit_plru_nxt;
          // a same-set touch is written after the hit update and replaces it
          if (upd_en_i) begin
            tag_q[upd_set_i][upd_way_i] <= upd_tag_i;
            st_q[upd_set_i][upd_way_i]  <= upd_state_i;
`ifdef TAG_PARITY_EN
            par_q[upd_set_i][upd_way_i] <= ^{upd_tag_i, upd_state_i};
`endif
            if (upd_touch_i) plru_q[upd_set_i] <= upd_plru_nxt;
          end
        end
        default: fsm_q <= FSM_INIT;
      endcase
    end
  end

`ifndef TAG_PARITY_EN
  assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
module tb_cache_tag_ctrl;
  import moesi_pkg::*;

  localparam int SETS = 128;
  localparam int WAYS = 4;
  localparam int TW   = 19;
  localparam int WB   = 2;
  localparam int SB   = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic init_busy, req_valid, req_ready, rsp_valid, rsp_hit;
  logic [31:0] req_addr, snp_addr;
  logic [WB-1:0] rsp_way, rsp_vict_way, snp_way, upd_way;
  logic [2:0] rsp_state, rsp_vict_state, snp_state, upd_state;
  logic [TW-1:0] rsp_vict_tag, upd_tag;
  logic snp_valid, snp_rsp_valid, snp_hit, upd_en, upd_touch, par_err;
  logic [SB-1:0] upd_set;

  cache_tag_ctrl dut (
    .clk_i(clk), .rst_i(rst), .init_busy_o(init_busy),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_way_o(rsp_way), .rsp_state_o(rsp_state),
    .rsp_vict_way_o(rsp_vict_way), .rsp_vict_tag_o(rsp_vict_tag), .rsp_vict_state_o(rsp_vict_state),
    .snp_valid_i(snp_valid), .snp_addr_i(snp_addr), .snp_rsp_valid_o(snp_rsp_valid),
    .snp_hit_o(snp_hit), .snp_way_o(snp_way), .snp_state_o(snp_state),
    .upd_en_i(upd_en), .upd_set_i(upd_set), .upd_way_i(upd_way), .upd_tag_i(upd_tag),
    .upd_state_i(upd_state), .upd_touch_i(upd_touch), .par_err_o(par_err)
  );

  typedef struct packed {
    logic hit; logic [WB-1:0] way; logic [2:0] st;
    logic [WB-1:0] vway; logic [TW-1:0] vtag; logic [2:0] vst;
  } core_t;
  typedef struct packed { logic hit; logic [WB-1:0] way; logic [2:0] st; } snp_t;

  core_t core_q[$];
  snp_t  snp_q[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  // reference model: plain arrays, PLRU as "which half is older" per tree node
  logic [TW-1:0] m_tag [SETS][WAYS];
  logic [2:0]    m_st  [SETS][WAYS];
  bit            m_node[SETS][WAYS-1];
  bit pend_v;
  int pend_set, pend_way;
  int set_pool[4] = '{0, 5, 9, 127};
  logic [2:0] st_pool[7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};

  function automatic bit m_valid(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100) || (s == 3'b101);
  endfunction

  function automatic int m_victim(input int s);
    int v; bit found;
    v = 0; found = 0;
    for (int i = 0; i < WAYS; i++)
      if (!found && !m_valid(m_st[s][i])) begin found = 1; v = i; end
    if (!found)
      for (int l = 0; l < WB; l++) v = 2*v + int'(m_node[s][(1<<l)-1+v]);
    return v;
  endfunction

  task automatic m_touch(input int s, input int w);
    for (int l = 0; l < WB; l++)
      m_node[s][(1<<l)-1 + (w >> (WB-l))] = (((w >> (WB-1-l)) & 1) == 0);
  endtask

  task automatic m_lookup(input int s, input int t, output logic hit,
                          output logic [WB-1:0] way, output logic [2:0] st);
    int n;
    n = 0; hit = 0; way = '0; st = 3'b000;
    for (int i = 0; i < WAYS; i++)
      if (m_valid(m_st[s][i]) && m_tag[s][i] == TW'(t)) begin
        n++; hit = 1; way = WB'(i); st = m_st[s][i];
      end
    if (n > 1) begin
      failures++;
      $display("FAIL multi_hit set=%0d got %0d hits, required at most 1", s, n);
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin m_tag[s][w] = '0; m_st[s][w] = 3'b000; end
      for (int n = 0; n < WAYS-1; n++) m_node[s][n] = 0;
    end
    pend_v = 0; pend_set = 0; pend_way = 0;
  endtask

  function automatic logic [31:0] mk_addr(input int s, input int t);
    logic [5:0] off;
    off = 6'($urandom_range(0, 63));
    return {TW'(t), SB'(s), off};
  endfunction

  task automatic idle();
    req_valid = 0; snp_valid = 0; upd_en = 0; upd_touch = 0;
  endtask

  task automatic garbage();
    req_valid = 1; req_addr = mk_addr(set_pool[$urandom_range(0,3)], $urandom_range(0,5));
    snp_valid = 1; snp_addr = mk_addr(set_pool[$urandom_range(0,3)], $urandom_range(0,5));
    upd_en = 1; upd_set = SB'(set_pool[$urandom_range(0,3)]); upd_way = WB'($urandom_range(0,3));
    upd_tag = TW'($urandom_range(0,5)); upd_state = 3'b100; upd_touch = 1;
  endtask

  task automatic do_cycle(input bit rv, input int rs, input int rt,
                          input bit sv, input int ss, input int stg,
                          input bit ue, input int us, input int uw, input int ut,
                          input logic [2:0] ust, input bit utouch);
    core_t ce; snp_t se;
    logic h; logic [WB-1:0] w; logic [2:0] st;
    int v;
    req_valid = rv; req_addr = mk_addr(rs, rt);
    snp_valid = sv; snp_addr = mk_addr(ss, stg);
    upd_en = ue; upd_set = SB'(us); upd_way = WB'(uw); upd_tag = TW'(ut);
    upd_state = ust; upd_touch = utouch;
    h = 0; w = '0;
    if (rv) begin
      m_lookup(rs, rt, h, w, st);
      v = m_victim(rs);
      ce = '{hit: h, way: w, st: st, vway: WB'(v), vtag: m_tag[rs][v], vst: m_st[rs][v]};
      core_q.push_back(ce);
    end
    if (sv) begin
      logic sh; logic [WB-1:0] sw; logic [2:0] sst;
      m_lookup(ss, stg, sh, sw, sst);
      se = '{hit: sh, way: sw, st: sst};
      snp_q.push_back(se);
    end
    if (pend_v && !(ue && utouch && us == pend_set)) m_touch(pend_set, pend_way);
    if (ue) begin
      m_tag[us][uw] = TW'(ut);
      m_st[us][uw]  = ust;
      if (utouch) m_touch(us, uw);
    end
    pend_v = rv && h; pend_set = rs; pend_way = int'(w);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        core_t act, exp_c;
        act = {rsp_hit, rsp_way, rsp_state, rsp_vict_way, rsp_vict_tag, rsp_vict_state};
        checks++;
        if (core_q.size() == 0) begin
          failures++;
          $display("FAIL core_unexpected got rsp_valid=1 with no request outstanding");
        end else begin
          exp_c = core_q.pop_front();
          if (act !== exp_c) begin
            failures++;
            $display("FAIL core_rsp got hit=%0d way=%0d st=%0d vway=%0d vtag=%0h vst=%0d required hit=%0d way=%0d st=%0d vway=%0d vtag=%0h vst=%0d",
                     act.hit, act.way, act.st, act.vway, act.vtag, act.vst,
                     exp_c.hit, exp_c.way, exp_c.st, exp_c.vway, exp_c.vtag, exp_c.vst);
          end
        end
        checks++;
        if (par_err !== 1'b0) begin
          failures++;
          $display("FAIL par_err got %0d required 0", par_err);
        end
      end
      if (snp_rsp_valid) begin
        snp_t sa, se;
        sa = {snp_hit, snp_way, snp_state};
        checks++;
        if (snp_q.size() == 0) begin
          failures++;
          $display("FAIL snp_unexpected got snp_rsp_valid=1 with no snoop outstanding");
        end else begin
          se = snp_q.pop_front();
          if (sa !== se) begin
            failures++;
            $display("FAIL snp_rsp got hit=%0d way=%0d st=%0d required hit=%0d way=%0d st=%0d",
                     sa.hit, sa.way, sa.st, se.hit, se.way, se.st);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    logic [47:0] outs;
    outs = {rsp_valid, rsp_hit, rsp_way, rsp_state, rsp_vict_way, rsp_vict_tag, rsp_vict_state,
            snp_rsp_valid, snp_hit, snp_way, snp_state, par_err};
    checks++;
    if (outs !== '0 || init_busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s got outs=%0h busy=%0d ready=%0d required outs=0 busy=1 ready=0",
               name, outs, init_busy, req_ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle(); req_addr = '0; snp_addr = '0; upd_set = '0; upd_way = '0; upd_tag = '0; upd_state = '0;
    rst = 1;
    @(posedge clk); #1;
    check_reset_outputs("reset_outputs");
    mon_en = 1;
    rst = 0;
    for (int i = 0; i < 50; i++) begin garbage(); @(posedge clk); #1; end
    checks++;
    if (init_busy !== 1'b1) begin failures++; $display("FAIL busy_mid_init got %0d required 1", init_busy); end

    // reset in the middle of the sweep restarts it
    rst = 1; garbage();
    @(posedge clk); #1;
    rst = 0;
    n = 0;
    while (init_busy && n < 400) begin n++; garbage(); @(posedge clk); #1; end
    idle();
    m_clear();
    checks++;
    if (n != SETS) begin failures++; $display("FAIL init_len got %0d cycles required %0d", n, SETS); end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL req_ready got %0d required 1", req_ready); end

    // lookups right after init all miss
    do_cycle(1, 5, 0, 1, 127, 3, 0, 0, 0, 0, 3'b000, 0);
    // single fill and hit
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5, 2, 'h1A3, 3'b100, 0);
    do_cycle(1, 5, 'h1A3, 1, 5, 'h1A3, 0, 0, 0, 0, 3'b000, 0);
    // fill set 9 way by way with a miss lookup alongside
    for (int w = 0; w < WAYS; w++) do_cycle(1, 9, 'h40, 0, 0, 0, 1, 9, w, 'h10 + w, 3'b100, 1);
    do_cycle(1, 9, 'h40, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    for (int w = 0; w < WAYS; w++) begin
      do_cycle(1, 9, 'h10 + w, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      do_cycle(1, 9, 'h40, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    end
    // snoop sees pre-write state while way 1 is invalidated
    do_cycle(0, 0, 0, 1, 9, 'h11, 1, 9, 1, 'h11, 3'b000, 0);
    do_cycle(1, 9, 'h11, 1, 9, 'h11, 0, 0, 0, 0, 3'b000, 0);
    // hit PLRU write colliding with a touch of another way in the same set
    do_cycle(0, 0, 0, 0, 0, 0, 1, 9, 1, 'h11, 3'b101, 1);
    do_cycle(1, 9, 'h10, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 9, 2, 'h12, 3'b001, 1);
    do_cycle(1, 9, 'h40, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    do_cycle(1, 9, 'h13, 0, 0, 0, 1, 9, 0, 'h10, 3'b010, 1);
    do_cycle(1, 9, 'h40, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);

    for (int c = 0; c < 2000; c++) begin
      bit rv, sv, ue, ut;
      int rs, rt, ss, stg, us, uw, utg;
      logic [2:0] ust;
      rv = ($urandom_range(0,3) != 0); rs = set_pool[$urandom_range(0,3)]; rt = $urandom_range(0,5);
      sv = ($urandom_range(0,2) != 0); ss = set_pool[$urandom_range(0,3)]; stg = $urandom_range(0,5);
      ue = ($urandom_range(0,2) == 0); us = set_pool[$urandom_range(0,3)]; uw = $urandom_range(0,3);
      utg = $urandom_range(0,5); ust = st_pool[$urandom_range(0,6)]; ut = ($urandom_range(0,1) == 1);
      if (m_valid(ust))
        for (int i = 0; i < WAYS; i++)
          if (i != uw && m_valid(m_st[us][i]) && m_tag[us][i] == TW'(utg)) ust = 3'b000;
      do_cycle(rv, rs, rt, sv, ss, stg, ue, us, uw, utg, ust, ut);
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (core_q.size() != 0 || snp_q.size() != 0) begin
      failures++;
      $display("FAIL outstanding got core=%0d snoop=%0d responses missing, required 0", core_q.size(), snp_q.size());
    end

    // synchronous reset clears registered outputs after activity
    do_cycle(1, 9, 'h10, 1, 9, 'h10, 0, 0, 0, 0, 3'b000, 0);
    idle();
    rst = 1;
    @(posedge clk); #1;
    check_reset_outputs("reset_after_run");
    rst = 0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
